// File: rtl/disp_pkg.sv
// Shared constants and helpers for the 7-segment scan controller.
package disp_pkg;

   localparam int          DISP_MAX_DIG = 16;
   localparam logic [3:0]  BCD_BLANK    = 4'hF;
   localparam logic [6:0]  SEG_OFF      = 7'h7F;
   localparam logic [DISP_MAX_DIG-1:0] AN_OFF = '1;

   // Active-low one-hot anode select for digit idx.
   function automatic logic [DISP_MAX_DIG-1:0] an_sel(input int unsigned idx);
      return ~(DISP_MAX_DIG'(1) << idx);
   endfunction

   // Leading-zero mask: zero digits from the top down, stopping at the first
   // non-zero one; digit 0 always stays visible.
   function automatic logic [DISP_MAX_DIG-1:0] lz_mask(
      input logic [4*DISP_MAX_DIG-1:0] digits,
      input int                        ndig
   );
      logic run;
      lz_mask = '0;
      run     = 1'b1;
      for (int i = DISP_MAX_DIG-1; i >= 1; i--) begin
         if (i < ndig) begin
            if (run && digits[4*i +: 4] == 4'h0) lz_mask[i] = 1'b1;
            else                                 run        = 1'b0;
         end
      end
   endfunction

endpackage

// File: rtl/bcd_7seg.sv
// BCD to 7-segment decoder, active-low segments {a,b,c,d,e,f,g}; non-BCD codes blank.
module bcd_7seg (
   input  logic [3:0] bcd,
   output logic [6:0] seg
);

   always_comb begin
      case (bcd)
         4'd0:    seg = 7'b0000001;
         4'd1:    seg = 7'b1001111;
         4'd2:    seg = 7'b0010010;
         4'd3:    seg = 7'b0000110;
         4'd4:    seg = 7'b1001100;
         4'd5:    seg = 7'b0100100;
         4'd6:    seg = 7'b0100000;
         4'd7:    seg = 7'b0001111;
         4'd8:    seg = 7'b0000000;
         4'd9:    seg = 7'b0000100;
         default: seg = 7'b1111111;
      endcase
   end

endmodule

// File: rtl/disp_scan.sv
// Time-multiplexed scan controller: one shared decoder, NDIG common-anode digits,
// ghost blanking, leading-zero suppression and edit blinking.
module disp_scan
   import disp_pkg::*;
#(
   parameter int NDIG         = 6,
   parameter int SCAN_DIV     = 50000,
   parameter int BLANK_CYC    = 500,
   parameter int BLINK_FRAMES = 83
) (
   input  logic              scan_clk,
   input  logic              scan_rst_n,
   input  logic              scan_en,
   input  logic [4*NDIG-1:0] scan_digits_in,
   input  logic [NDIG-1:0]   scan_blink_in,
   input  logic              scan_lzb_en,
   output logic [6:0]        scan_seg_out,
   output logic [NDIG-1:0]   scan_an_out,
   output logic              scan_frame_out
);

   localparam int IW = (NDIG > 1)         ? $clog2(NDIG)         : 1;
   localparam int DW = $clog2(SCAN_DIV);
   localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

   logic [DW-1:0]         div_cnt_q, div_cnt_d;
   logic [IW-1:0]         idx_q, idx_d;
   logic [BW-1:0]         blink_cnt_q, blink_cnt_d;
   logic                  phase_q, phase_d;
   logic [NDIG-1:0][3:0]  shadow_q, shadow_d;
   logic [NDIG-1:0]       blink_sh_q, blink_sh_d;
   logic [NDIG-1:0]       lz_q, lz_d;
   logic [NDIG-1:0]       an_q, an_d;
   logic [3:0]            bcd_q, bcd_d;
   logic                  frame_q, frame_d;
   logic                  tick, snap;

   always_comb begin
      div_cnt_d   = div_cnt_q;
      idx_d       = idx_q;
      blink_cnt_d = blink_cnt_q;
      phase_d     = phase_q;
      shadow_d    = shadow_q;
      blink_sh_d  = blink_sh_q;
      lz_d        = lz_q;

      tick = scan_en && (div_cnt_q == DW'(SCAN_DIV-1));
      snap = tick && (idx_q == IW'(NDIG-1));

      if (scan_en) div_cnt_d = tick ? '0 : div_cnt_q + 1'b1;
      if (tick)    idx_d     = (idx_q == IW'(NDIG-1)) ? '0 : idx_q + 1'b1;

      // Snapshot at end of frame so a whole frame shows one consistent value.
      if (snap) begin
         shadow_d   = scan_digits_in;
         blink_sh_d = scan_blink_in;
         lz_d       = scan_lzb_en ? NDIG'(lz_mask((4*DISP_MAX_DIG)'(scan_digits_in), NDIG)) : '0;
         if (blink_cnt_q == BW'(BLINK_FRAMES-1)) begin
            blink_cnt_d = '0;
            phase_d     = ~phase_q;
         end else begin
            blink_cnt_d = blink_cnt_q + 1'b1;
         end
      end

      frame_d = snap;
      // Anodes stay off for the first BLANK_CYC cycles of every slot to hide ghosting.
      an_d    = (scan_en && int'(div_cnt_q) >= BLANK_CYC) ? NDIG'(an_sel(32'(idx_q)))
                                                           : NDIG'(AN_OFF);
      bcd_d   = (lz_q[idx_q] || (phase_q && blink_sh_q[idx_q])) ? BCD_BLANK : shadow_q[idx_q];
   end

   always_ff @(posedge scan_clk or negedge scan_rst_n) begin
      if (!scan_rst_n) begin
         div_cnt_q   <= '0;
         idx_q       <= '0;
         blink_cnt_q <= '0;
         phase_q     <= 1'b0;
         shadow_q    <= {NDIG{BCD_BLANK}};
         blink_sh_q  <= '0;
         lz_q        <= '0;
         an_q        <= '1;
         bcd_q       <= BCD_BLANK;
         frame_q     <= 1'b0;
      end else begin
         div_cnt_q   <= div_cnt_d;
         idx_q       <= idx_d;
         blink_cnt_q <= blink_cnt_d;
         phase_q     <= phase_d;
         shadow_q    <= shadow_d;
         blink_sh_q  <= blink_sh_d;
         lz_q        <= lz_d;
         an_q        <= an_d;
         bcd_q       <= bcd_d;
         frame_q     <= frame_d;
      end
   end

   bcd_7seg u_dec (
      .bcd (bcd_q),
      .seg (scan_seg_out)
   );

   assign scan_an_out    = an_q;
   assign scan_frame_out = frame_q;

endmodule

// File: tb/tb_disp_scan.sv
// Self-checking bench for disp_scan: directed steps plus random traffic against a
// frame/slot-level reference model.
module tb_disp_scan;

   localparam int NDIG = 4, SCAN_DIV = 4, BLANK_CYC = 1, BLINK_FRAMES = 2;
   localparam int NF   = NDIG * SCAN_DIV;

   logic            clk = 1'b0;
   logic            rst_n;
   logic            en;
   logic [15:0]     digits;
   logic [3:0]      blink;
   logic            lzb;
   logic [6:0]      seg;
   logic [3:0]      an;
   logic            frame;

   int total = 0;
   int bad   = 0;

   // Reference model state: enabled cycles since reset and last snapshot contents.
   int          n;
   int          k;
   logic [15:0] sd;
   logic [3:0]  sb;
   logic        slz;

   always #5 clk = ~clk;

   disp_scan #(
      .NDIG(NDIG), .SCAN_DIV(SCAN_DIV), .BLANK_CYC(BLANK_CYC), .BLINK_FRAMES(BLINK_FRAMES)
   ) dut (
      .scan_clk       (clk),
      .scan_rst_n     (rst_n),
      .scan_en        (en),
      .scan_digits_in (digits),
      .scan_blink_in  (blink),
      .scan_lzb_en    (lzb),
      .scan_seg_out   (seg),
      .scan_an_out    (an),
      .scan_frame_out (frame)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s got=%h exp=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [6:0] seg_of(input logic [3:0] c);
      case (c)
         4'd0: return 7'b0000001;  4'd1: return 7'b1001111;
         4'd2: return 7'b0010010;  4'd3: return 7'b0000110;
         4'd4: return 7'b1001100;  4'd5: return 7'b0100100;
         4'd6: return 7'b0100000;  4'd7: return 7'b0001111;
         4'd8: return 7'b0000000;  4'd9: return 7'b0000100;
         default: return 7'b1111111;
      endcase
   endfunction

   // Digit code shown for slot s given the current snapshot.
   function automatic logic [3:0] exp_code(input int s);
      int h;
      h = 0;
      for (int i = 0; i < NDIG; i++) if (sd[4*i +: 4] != 4'h0) h = i;
      if (k == 0)                                         return 4'hF;
      if (slz && s > h)                                   return 4'hF;
      if (((k / BLINK_FRAMES) % 2) == 1 && sb[s])         return 4'hF;
      return sd[4*s +: 4];
   endfunction

   task automatic model_reset();
      n = 0; k = 0; sd = 16'hFFFF; sb = 4'h0; slz = 1'b0;
   endtask

   task automatic chk_reset_outs(input string tag);
      chk({tag, "_seg"},   32'(seg),   32'h7F);
      chk({tag, "_an"},    32'(an),    32'hF);
      chk({tag, "_frame"}, 32'(frame), 32'h0);
   endtask

   // One clock: predict outputs from pre-edge model state, advance model, compare.
   task automatic cyc();
      int pos, slot, dv, pc;
      logic [3:0] e_an;
      logic [6:0] e_seg;
      logic       e_frame;
      pos     = n % NF;
      slot    = pos / SCAN_DIV;
      dv      = pos % SCAN_DIV;
      e_an    = (en && dv >= BLANK_CYC) ? ~(4'b0001 << slot) : 4'hF;
      e_seg   = seg_of(exp_code(slot));
      e_frame = 1'b0;
      if (en) begin
         if (pos == NF-1) begin
            sd = digits; sb = blink; slz = lzb; k++; e_frame = 1'b1;
         end
         n++;
      end
      @(posedge clk); #1;
      chk("an",    32'(an),    32'(e_an));
      chk("seg",   32'(seg),   32'(e_seg));
      chk("frame", 32'(frame), 32'(e_frame));
      pc = 0;
      for (int i = 0; i < NDIG; i++) if (an[i] == 1'b0) pc++;
      chk("an_onehot", 32'(pc <= 1), 32'd1);
   endtask

   function automatic logic [15:0] rnd_digits();
      logic [15:0] d;
      for (int i = 0; i < NDIG; i++) begin
         case ($urandom_range(0, 3))
            0:       d[4*i +: 4] = 4'($urandom_range(0, 15));
            1:       d[4*i +: 4] = 4'h0;
            default: d[4*i +: 4] = 4'($urandom_range(0, 9));
         endcase
      end
      return d;
   endfunction

   initial begin
      rst_n = 1'b0; en = 1'b0; digits = '0; blink = '0; lzb = 1'b0;
      model_reset();

      // Reset held while inputs toggle.
      repeat (5) begin
         digits = 16'($urandom); blink = 4'($urandom); lzb = 1'($urandom); en = 1'b1;
         @(posedge clk); #1;
         chk_reset_outs("rst_hold");
      end
      rst_n = 1'b1;

      // Plain display of 1234; first frame blank, pulse on 16th cycle.
      en = 1'b1; lzb = 1'b0; blink = '0; digits = 16'h1234;
      repeat (NF) cyc();
      cyc();
      cyc();
      chk("first_digit_an",  32'(an),  32'(4'b1110));
      chk("first_digit_seg", 32'(seg), 32'(7'b1001100));
      repeat (NF - 2) cyc();

      // Leading-zero blanking.
      digits = 16'h0070; lzb = 1'b1;
      repeat (2*NF) cyc();
      digits = 16'h0000;
      repeat (2*NF) cyc();

      // Blinking digits 1,0.
      lzb = 1'b0; digits = 16'h1234; blink = 4'b0011;
      repeat (6*NF) cyc();

      // Mid-frame input change and enable drop mid-slot.
      blink = '0;
      repeat (5) cyc();
      digits = 16'h9876;
      repeat (6) cyc();
      en = 1'b0;
      repeat (5) cyc();
      en = 1'b1;
      repeat (2*NF) cyc();

      // Async reset mid-slot clears outputs immediately.
      repeat (6) cyc();
      rst_n = 1'b0;
      #1;
      chk_reset_outs("rst_async");
      @(posedge clk); #1;
      chk_reset_outs("rst_async_hold");
      model_reset();
      rst_n = 1'b1;
      repeat (NF + 3) cyc();

      // Random traffic.
      repeat (600) begin
         if ($urandom_range(0, 5) == 0) digits = rnd_digits();
         if ($urandom_range(0, 15) == 0) blink = 4'($urandom);
         if ($urandom_range(0, 15) == 0) lzb = 1'($urandom);
         en = ($urandom_range(0, 9) != 0);
         cyc();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
